// File: rtl/mmio_pwm_pkg.sv
// mmio_pwm_pkg: register map and CTRL bit positions shared by the
// mmio_pwm_bank top and its pwm_channel sub-module.
// Optional feature macro: PWM_CENTER_ALIGNED_EN (enables CTRL.MODE).
package mmio_pwm_pkg;

    localparam logic [7:0]  OFF_CTRL    = 8'h00;
    localparam logic [7:0]  OFF_LEDS    = 8'h04;
    localparam logic [7:0]  OFF_STATUS  = 8'h08;
    localparam logic [7:0]  OFF_CH_BASE = 8'h10;
    localparam int unsigned CH_STRIDE   = 8;

    localparam int unsigned SYNC_BIT = 31;
    localparam int unsigned MODE_BIT = 16;

    // Word offset of PERIOD_ch; DUTY_ch sits 4 bytes above it.
    function automatic logic [7:0] period_off(input int unsigned ch);
        return 8'(32'(OFF_CH_BASE) + CH_STRIDE * ch);
    endfunction

    function automatic logic [7:0] duty_off(input int unsigned ch);
        return 8'(32'(OFF_CH_BASE) + CH_STRIDE * ch + 32'd4);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with counter, shadow-to-active transfer,
// registered output and a one-cycle wrap pulse.
// Optional feature macro: PWM_CENTER_ALIGNED_EN adds the center input and
// an up/down direction flop.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   en             channel enable (CTRL bit)
//   center         1 = center-aligned counting (only with the macro)
//   sync           restart counter at 0 and load shadows this edge
//   shadow_period  PERIOD shadow register
//   shadow_duty    DUTY shadow register
//   pwm            registered PWM output (lags cnt by one cycle)
//   wrap           high on the cycle the active registers reload
module pwm_channel
    import mmio_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic             center,
`endif
    input  logic             sync,
    input  logic [CNT_W-1:0] shadow_period,
    input  logic [CNT_W-1:0] shadow_duty,
    output logic             pwm,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_duty;

`ifdef PWM_CENTER_ALIGNED_EN
    // Idle state is "down" so the first 0 after enable counts as a wrap.
    logic dir_down;

    always_comb begin
        if (center) begin
            wrap = en & dir_down & (cnt == '0);
        end else begin
            wrap = en & (cnt >= act_period);
        end
    end

    always_comb begin
        cnt_next = cnt + 1'b1;
        if (center) begin
            if (dir_down) begin
                if (cnt == '0) begin
                    cnt_next = (shadow_period == '0) ? '0 : CNT_W'(1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end else if (cnt >= act_period) begin
                cnt_next = cnt - 1'b1;
            end
        end else if (wrap) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !en || sync || !center) begin
            dir_down <= 1'b1;
        end else if (dir_down) begin
            if (cnt == '0 && shadow_period != '0) begin
                dir_down <= 1'b0;
            end
        end else if (cnt >= act_period) begin
            dir_down <= 1'b1;
        end
    end
`else
    assign wrap = en & (cnt >= act_period);

    always_comb begin
        cnt_next = wrap ? '0 : cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            act_period <= '0;
            act_duty   <= '0;
            pwm        <= 1'b0;
        end else if (!en || sync) begin
            // Disabled or resynchronised: hold at 0 and keep actives
            // following the shadows so a restart uses current values.
            cnt        <= '0;
            act_period <= shadow_period;
            act_duty   <= shadow_duty;
            pwm        <= 1'b0;
        end else begin
            cnt <= cnt_next;
            pwm <= (cnt < act_duty);
            if (wrap) begin
                act_period <= shadow_period;
                act_duty   <= shadow_duty;
            end
        end
    end

endmodule

// File: rtl/mmio_pwm_bank.sv
// mmio_pwm_bank: memory-mapped bank of NUM_CH double-buffered PWM channels
// plus an NUM_LEDS-bit LED register, decoded in a 256-byte window at
// BASE_ADDR on the multicycle RISC-V data bus.
// Optional feature macro: PWM_CENTER_ALIGNED_EN (CTRL bit 16 = center mode).
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   we          bus write strobe
//   addr        byte address (addr[1:0] ignored)
//   wdata       write data
//   rdata       combinational read data, 0 when hit=0
//   hit         addr is inside this block's window
//   leds        LED register
//   pwm_out     PWM outputs, one per channel
module mmio_pwm_bank
    import mmio_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned NUM_LEDS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                hit,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_CH-1:0]   pwm_out
);

    logic [7:0]        off;
    logic              wr;
    logic              sync;
    logic [NUM_CH-1:0] ctrl_en;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] wrap;
    logic [CNT_W-1:0]  shadow_period [NUM_CH];
    logic [CNT_W-1:0]  shadow_duty   [NUM_CH];
    logic              unused_ok;
`ifdef PWM_CENTER_ALIGNED_EN
    logic              mode_q;
`endif

    assign hit       = (addr[31:8] == BASE_ADDR[31:8]);
    assign off       = {addr[7:2], 2'b00};
    assign wr        = we & hit;
    assign sync      = wr & (off == OFF_CTRL) & wdata[SYNC_BIT];
    assign unused_ok = ^{addr[1:0], wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en <= '0;
            leds    <= '0;
            status  <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_q  <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_period[i] <= '0;
                shadow_duty[i]   <= '0;
            end
        end else begin
            if (wr && off == OFF_CTRL) begin
                ctrl_en <= wdata[NUM_CH-1:0];
`ifdef PWM_CENTER_ALIGNED_EN
                mode_q  <= wdata[MODE_BIT];
`endif
            end
            if (wr && off == OFF_LEDS) begin
                leds <= wdata[NUM_LEDS-1:0];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // A wrap in the same cycle as a W1C keeps the flag set.
                status[i] <= wrap[i] |
                             (status[i] & ~(wr && off == OFF_STATUS && wdata[i]));
                if (wr && off == period_off(i)) begin
                    shadow_period[i] <= wdata[CNT_W-1:0];
                end
                if (wr && off == duty_off(i)) begin
                    shadow_duty[i] <= wdata[CNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            if (off == OFF_CTRL) begin
                rdata[NUM_CH-1:0] = ctrl_en;
`ifdef PWM_CENTER_ALIGNED_EN
                rdata[MODE_BIT] = mode_q;
`endif
            end
            if (off == OFF_LEDS) begin
                rdata[NUM_LEDS-1:0] = leds;
            end
            if (off == OFF_STATUS) begin
                rdata[NUM_CH-1:0] = status;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (off == period_off(i)) begin
                    rdata = 32'(shadow_period[i]);
                end
                if (off == duty_off(i)) begin
                    rdata = 32'(shadow_duty[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .en           (ctrl_en[g]),
`ifdef PWM_CENTER_ALIGNED_EN
            .center       (mode_q),
`endif
            .sync         (sync),
            .shadow_period(shadow_period[g]),
            .shadow_duty  (shadow_duty[g]),
            .pwm          (pwm_out[g]),
            .wrap         (wrap[g])
        );
    end

endmodule

// File: tb/tb_mmio_pwm_bank.sv
// tb_mmio_pwm_bank: directed stimulus for mmio_pwm_bank. Stimulus pushes
// expected values for the current cycle into a scoreboard queue; a monitor
// on the falling edge pops and compares them against the DUT outputs.
// With PWM_CENTER_ALIGNED_EN defined an extra center-mode sequence runs.
module tb_mmio_pwm_bank;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NUM_LEDS = 4;
    localparam logic [31:0] BASE     = 32'h0000_2000;

    localparam int K_RD  = 0;
    localparam int K_HIT = 1;
    localparam int K_PWM = 2;
    localparam int K_LED = 3;

    typedef struct {
        int unsigned cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
        logic [95:0] name;
    } chk_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                we = 1'b0;
    logic [31:0]         addr = '0;
    logic [31:0]         wdata = '0;
    logic [31:0]         rdata;
    logic                hit;
    logic [NUM_LEDS-1:0] leds;
    logic [NUM_CH-1:0]   pwm_out;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    chk_t        sb[$];
    chk_t        cur;
    logic [31:0] act;

    mmio_pwm_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .NUM_LEDS (NUM_LEDS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .leds   (leds),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_exp(input int kind, input int idx,
                                     input logic [31:0] exp, input logic [95:0] name);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endfunction

    // Monitor: compare every expectation registered for this cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            case (cur.kind)
                K_RD:    act = rdata;
                K_HIT:   act = {31'b0, hit};
                K_PWM:   act = {31'b0, pwm_out[cur.idx]};
                default: act = 32'(leds);
            endcase
            n_tests++;
            if (act !== cur.exp || cur.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s idx=%0d cyc=%0d got=%h exp=%h", cur.name, cur.idx,
                         cyc, act, cur.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        wr_abs(BASE + {24'h0, o}, d);
    endtask

    task automatic rd(input logic [7:0] o, input logic [31:0] e, input logic [95:0] nm);
        we   = 1'b0;
        addr = BASE + {24'h0, o};
        push_exp(K_RD, 0, e, nm);
        push_exp(K_HIT, 0, 32'd1, "hit");
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          e_pwm;
        int          e_st;
        logic [7:0]  ctbl;

        // Reset held across two edges.
        step();
        step();
        reset = 1'b0;
        push_exp(K_LED, 0, 32'd0, "leds_rst");
        for (int i = 0; i < 4; i++) push_exp(K_PWM, i, 32'd0, "pwm_rst");
        for (int unsigned o = 0; o < 32'h30; o += 4) rd(8'(o), 32'd0, "rd_rst");
        rd(8'hFC, 32'd0, "rd_unmapped");

        // Outside the window: no hit, rdata 0, writes ignored.
        addr = BASE + 32'h100;
        push_exp(K_RD, 0, 32'd0, "rd_miss");
        push_exp(K_HIT, 0, 32'd0, "hit_miss");
        step();
        wr_abs(BASE + 32'h104, 32'h5);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd(8'h0C, 32'd0, "rd_unmap_wr");
        push_exp(K_LED, 0, 32'd0, "leds_miss");
        rd(8'h04, 32'd0, "rd_leds0");

        // Truncation on write, zero-extension on read.
        wr(8'h10, 32'h0001_2345);
        rd(8'h10, 32'h0000_2345, "rd_trunc");

        // LEDS write: hit asserted during the access.
        we = 1'b1;
        addr = BASE + 32'h04;
        wdata = 32'hFFFF_FFFA;
        push_exp(K_HIT, 0, 32'd1, "hit_wr");
        step();
        we = 1'b0;
        push_exp(K_LED, 0, 32'hA, "leds_a");
        rd(8'h04, 32'hA, "rd_leds");

        // Channel 0: period 9, duty 3. Cycle j=0 is the first enabled cycle.
        // STATUS W1C at j=25 (no wrap) and j=39 (wrap cycle, set wins);
        // DUTY_0=7 written at j=33 takes effect after the wrap at j=39.
        wr(8'h10, 32'd9);
        wr(8'h14, 32'd3);
        wr(8'h00, 32'd1);
        for (int j = 0; j < 60; j++) begin
            we    = 1'b0;
            addr  = BASE + 32'h08;
            wdata = 32'd0;
            if (j == 25 || j == 39) begin
                we    = 1'b1;
                wdata = 32'd1;
            end
            if (j == 33) begin
                we    = 1'b1;
                addr  = BASE + 32'h14;
                wdata = 32'd7;
            end
            e_pwm = (j == 0) ? 0 : int'(((j - 1) % 10) < ((((j - 1) / 10) >= 4) ? 7 : 3));
            e_st  = (j < 10) ? 0 : (j <= 25) ? 1 : (j < 30) ? 0 : 1;
            push_exp(K_PWM, 0, 32'(e_pwm), "pwm0_basic");
            push_exp(K_RD, 0, (j == 33) ? 32'd3 : 32'(e_st), "rd_status");
            if (j % 10 == 5) begin
                for (int k = 1; k < 4; k++) push_exp(K_PWM, k, 32'd0, "pwm_dis");
            end
            step();
        end
        we = 1'b0;

        // Edge values on ch1..3, then SYNC with all enables.
        // Ch1 duty 0 -> low; ch2 period 0 duty 1 -> high, wraps each cycle;
        // ch3 duty 20 > period 9 -> high. W1C of all flags at j=0.
        wr(8'h18, 32'd9);
        wr(8'h1C, 32'd0);
        wr(8'h20, 32'd0);
        wr(8'h24, 32'd1);
        wr(8'h28, 32'd9);
        wr(8'h2C, 32'd20);
        wr(8'h00, 32'h8000_000F);
        for (int j = 0; j < 21; j++) begin
            we    = 1'b0;
            addr  = BASE + 32'h08;
            wdata = 32'd0;
            if (j == 0) begin
                we    = 1'b1;
                wdata = 32'hF;
            end
            e_st  = (j == 0) ? 1 : (j < 10) ? 4 : 15;
            e_pwm = (j == 0) ? 0 : int'(((j - 1) % 10) < 7);
            push_exp(K_RD, 0, 32'(e_st), "rd_status2");
            push_exp(K_PWM, 0, 32'(e_pwm), "pwm0_sync");
            push_exp(K_PWM, 1, 32'd0, "pwm1_duty0");
            push_exp(K_PWM, 2, (j == 0) ? 32'd0 : 32'd1, "pwm2_per0");
            push_exp(K_PWM, 3, (j == 0) ? 32'd0 : 32'd1, "pwm3_dbig");
            step();
        end
        we = 1'b0;
        rd(8'h00, 32'hF, "rd_ctrl");
        push_exp(K_LED, 0, 32'hA, "leds_hold");
        step();

        // Mid-operation reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_exp(K_LED, 0, 32'd0, "leds_rst2");
        for (int i = 0; i < 4; i++) push_exp(K_PWM, i, 32'd0, "pwm_rst2");
        rd(8'h00, 32'd0, "rd_ctrl_rst");
        rd(8'h08, 32'd0, "rd_stat_rst");
        rd(8'h18, 32'd0, "rd_per_rst");
        rd(8'h14, 32'd0, "rd_duty_rst");

`ifdef PWM_CENTER_ALIGNED_EN
        // Center mode, period 4 duty 2: cnt runs 0,1,2,3,4,3,2,1 (8 clocks);
        // cnt<2 holds at 1(down),0,1(up), one contiguous pulse per cycle.
        ctbl = 8'b1000_0011;
        wr(8'h10, 32'd4);
        wr(8'h14, 32'd2);
        wr(8'h00, 32'h0001_0001);
        for (int k = 0; k < 24; k++) begin
            e_pwm = (k == 0) ? 0 : int'(ctbl[(k - 1) % 8]);
            push_exp(K_PWM, 0, 32'(e_pwm), "pwm0_center");
            step();
        end
        rd(8'h00, 32'h0001_0001, "rd_ctrl_ctr");
`else
        ctbl = 8'h00;
`endif

        step();
        step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0 pending", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
